lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning max cycles waiting for bus_ack before abort (legal range 1-255).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block uses one clock only.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request for a memory op.
REQ-005 SHALL have port mem_read  input  1  op is load.
REQ-006 SHALL have port mem_write  input  1  op is store.
REQ-007 SHALL have port funct3  input  3  [1:0] size (00 B, 01 H, 10 W, 11 D); [2] = unsigned load.
REQ-008 SHALL have port addr  input  64  byte address (ALU result).
REQ-009 SHALL have port wdata  input  64  store data, right-justified.
REQ-010 SHALL have port stall  output  1  freeze pipeline/PC.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rdata  output  64  extended load result, valid while done=1.
REQ-013 SHALL have port err  output  2  00 ok, 01 misaligned, 10 illegal, 11 timeout; valid while done=1.
REQ-014 SHALL have port bus_req  output  1  bus request.
REQ-015 SHALL have port bus_we  output  1  1 = write.
REQ-016 SHALL have port bus_addr  output  64  doubleword-aligned address.
REQ-017 SHALL have port bus_wdata  output  64  lane-positioned store data.
REQ-018 SHALL have port bus_be  output  8  byte enables.
REQ-019 SHALL have port bus_ack  input  1  bus completion.
REQ-020 SHALL have port bus_rdata  input  64  read doubleword, valid with bus_ack.

Function
REQ-021 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-022 IDLE + start + legal op -> capture op/addr/wdata, go BUSY.
REQ-023 IDLE + start + illegal or misaligned -> go DONE with err set; no bus_req ever asserted.
REQ-024 Illegal: mem_read==mem_write; load with funct3=111; store with funct3[2]=1.
REQ-025 Misaligned: (addr[2:0] & (size_bytes-1)) != 0; illegal takes priority over misaligned.
REQ-026 In BUSY: bus_req=1; bus_we/addr/wdata/be held constant until the ack cycle.
REQ-027 BUSY + bus_ack -> go DONE; register the extended load data.
REQ-028 BUSY without ack for TIMEOUT consecutive cycles -> go DONE with err=11.
REQ-029 DONE lasts exactly one cycle: done=1, then unconditionally to IDLE.
REQ-030 bus_addr = {addr[63:3],000}.
REQ-031 bus_be = (1,3,F,FF by size) << addr[2:0].
REQ-032 bus_wdata = wdata << 8*addr[2:0]; upper bits truncated to 64.
REQ-033 rdata = (bus_rdata >> 8*addr[2:0]), truncated to size, then sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1).
REQ-034 rdata = 0 on stores and on any err != 00.
REQ-035 stall = (IDLE & start & (mem_read|mem_write)) | BUSY; stall=0 in DONE.
REQ-036 Timing: start at cycle 0, bus_req from cycle 1, ack at cycle k, done at cycle k+1.
REQ-037 Error path: done at cycle 1.
REQ-038 start while BUSY or DONE is ignored.
REQ-039 bus_ack while not BUSY is ignored.

Reset
REQ-040 rst_n=0 at a rising edge -> state IDLE, timeout counter 0.
REQ-041 Reset values: stall=0, done=0, rdata=0, err=00, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=00.
REQ-042 Reset during BUSY drops bus_req at that edge; no done pulse is issued for the aborted op.

Verification
REQ-043 LB, addr=0x1003, bus_rdata=0x0000_0000_8000_0000, ack at cycle 2 -> bus_be=0x08, bus_addr=0x1000, done at cycle 3, rdata=0xFFFF_FFFF_FFFF_FF80, err=00.
REQ-044 LWU, addr=0x2004, bus_rdata=0xDEADBEEF_00000000 -> rdata=0x0000_0000_DEAD_BEEF.
REQ-045 SH, addr=0x10, wdata=0x1234 -> bus_we=1, bus_be=0x03, bus_wdata=0x1234.
REQ-046 SH, addr=0x16, wdata=0x1234 -> bus_be=0xC0, bus_wdata=0x1234_0000_0000_0000.
REQ-047 LD, addr=0x0C -> no bus_req, done at cycle 1, err=01; LDU (funct3=111) at any address -> err=10.
REQ-048 TIMEOUT=4, no ack -> bus_req high for cycles 1-4, done at cycle 5, err=11.
REQ-049 rst_n=0 during BUSY -> bus_req=0 and stall=0 after that edge; no done pulse.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: one memory op at a time over a doubleword bus.
// Handles lane placement, load extension, alignment checks and bus timeout.
module lsu #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [63:0] rdata,
  output logic [1:0]  err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_be,
  input  logic        bus_ack,
  input  logic [63:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] size_q;
  logic       uns_q;
  logic [2:0] off_q;

  logic       illegal;
  logic       misaligned;
  logic [2:0] mask;
  logic [7:0] be_base;

  always_comb begin
    mask    = 3'd0;
    be_base = 8'h01;
    unique case (funct3[1:0])
      2'b00: begin mask = 3'd0; be_base = 8'h01; end
      2'b01: begin mask = 3'd1; be_base = 8'h03; end
      2'b10: begin mask = 3'd3; be_base = 8'h0F; end
      2'b11: begin mask = 3'd7; be_base = 8'hFF; end
      default: ;
    endcase
    illegal = (mem_read == mem_write)
            | (mem_read & (funct3 == 3'b111))
            | (mem_write & funct3[2]);
    misaligned = |(addr[2:0] & mask);
  end

  assign stall = ((state == IDLE) & start & (mem_read | mem_write))
               | (state == BUSY);

  function automatic logic [63:0] extend(
    input logic [63:0] d,
    input logic [2:0]  off,
    input logic [1:0]  size,
    input logic        uns
  );
    logic [63:0] sh;
    logic [63:0] r;
    sh = d >> {off, 3'b000};
    r  = sh;
    unique case (size)
      2'b00: r = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
      2'b01: r = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'b10: r = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      2'b11: r = sh;
      default: ;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
      off_q     <= 3'd0;
      done      <= 1'b0;
      rdata     <= 64'd0;
      err       <= 2'b00;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 64'd0;
      bus_wdata <= 64'd0;
      bus_be    <= 8'h00;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (illegal) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 2'b10;
            end else if (misaligned) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 2'b01;
            end else begin
              state     <= BUSY;
              cnt       <= 8'd0;
              size_q    <= funct3[1:0];
              uns_q     <= funct3[2];
              off_q     <= addr[2:0];
              bus_req   <= 1'b1;
              bus_we    <= mem_write;
              bus_addr  <= {addr[63:3], 3'b000};
              bus_be    <= be_base << addr[2:0];
              bus_wdata <= wdata << {addr[2:0], 3'b000};
            end
          end
        end
        BUSY: begin
          if (bus_ack) begin
            state   <= DONE;
            done    <= 1'b1;
            bus_req <= 1'b0;
            err     <= 2'b00;
            rdata   <= bus_we ? 64'd0
                              : extend(bus_rdata, off_q, size_q, uns_q);
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            state   <= DONE;
            done    <= 1'b1;
            bus_req <= 1'b0;
            err     <= 2'b11;
            rdata   <= 64'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          rdata <= 64'd0;
          err   <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
